// File: rtl/program_flow_unit_if.sv
// program_flow_unit_if: decoder/fetch-side bus of the program flow unit
interface program_flow_unit_if #(
   parameter int SP_W = 5
);
   logic            step;
   logic            JMP_flag;
   logic            CALL_flag;
   logic            RET_flag;
   logic            PUSH_flag;
   logic            POP_flag;
   logic [15:0]     target;
   logic [31:0]     push_data;
   logic [15:0]     PC_pos;
   logic [31:0]     pop_data;
   logic            pop_valid;
   logic [SP_W-1:0] stack_ptr;
   logic            fault;
   logic [1:0]      fault_code;
   modport master (
      output step, JMP_flag, CALL_flag, RET_flag, PUSH_flag, POP_flag, target, push_data,
      input  PC_pos, pop_data, pop_valid, stack_ptr, fault, fault_code
   );
   modport slave (
      input  step, JMP_flag, CALL_flag, RET_flag, PUSH_flag, POP_flag, target, push_data,
      output PC_pos, pop_data, pop_valid, stack_ptr, fault, fault_code
   );
endinterface

// File: rtl/program_flow_unit.sv
// program_flow_unit: program counter and call/data stack; FLOW_FAULT_CLEAR_EN adds fault_clear
module program_flow_unit #(
   parameter int          DEPTH    = 16,
   parameter int          SP_W     = 5,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input logic clk,
   input logic rst,
`ifdef FLOW_FAULT_CLEAR_EN
   input logic fault_clear,
`endif
   program_flow_unit_if.slave bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   typedef enum logic {S_RUN, S_FAULT} state_t;
   state_t          r_state, w_state_nxt;
   logic [15:0]     r_pc, w_pc_nxt, w_pc_inc;
   logic [SP_W-1:0] r_sp, w_sp_nxt, w_sp_dec;
   logic [31:0]     r_pop_data, w_pop_data_nxt, w_wdata, w_top;
   logic            r_pop_valid, w_pop_valid_nxt, w_we;
   logic [1:0]      r_code, w_code_nxt;
   logic [31:0]     r_mem [DEPTH];
   logic [4:0]      w_flags;
   logic            w_multi, w_full, w_empty, w_grow, w_shrink;
   logic [AW-1:0]   w_rd_idx, w_wr_idx;
   assign w_flags  = {bus.JMP_flag, bus.CALL_flag, bus.RET_flag, bus.PUSH_flag, bus.POP_flag};
   assign w_multi  = (w_flags & (w_flags - 5'd1)) != 5'd0;
   assign w_grow   = bus.CALL_flag | bus.PUSH_flag;
   assign w_shrink = bus.RET_flag | bus.POP_flag;
   assign w_full   = r_sp == SP_W'(DEPTH);
   assign w_empty  = r_sp == '0;
   assign w_pc_inc = r_pc + 16'd1;
   assign w_sp_dec = r_sp - 1'b1;
   assign w_rd_idx = AW'(w_sp_dec);
   assign w_wr_idx = AW'(r_sp);
   assign w_top    = r_mem[w_rd_idx];
   // next-state and datapath decisions for the committed instruction
   always_comb begin
      w_state_nxt     = r_state;
      w_pc_nxt        = r_pc;
      w_sp_nxt        = r_sp;
      w_pop_data_nxt  = r_pop_data;
      w_pop_valid_nxt = 1'b0;
      w_code_nxt      = r_code;
      w_we            = 1'b0;
      w_wdata         = bus.CALL_flag ? {16'b0, w_pc_inc} : bus.push_data;
      if (r_state == S_RUN && bus.step) begin
         if (w_multi) begin
            w_state_nxt = S_FAULT;
            w_code_nxt  = 2'd3;
         end else if (w_grow && w_full) begin
            w_state_nxt = S_FAULT;
            w_code_nxt  = 2'd1;
         end else if (w_shrink && w_empty) begin
            w_state_nxt = S_FAULT;
            w_code_nxt  = 2'd2;
         end else begin
            w_pc_nxt        = (bus.JMP_flag | bus.CALL_flag) ? bus.target :
                              bus.RET_flag ? w_top[15:0] : w_pc_inc;
            w_sp_nxt        = w_grow ? r_sp + 1'b1 : w_shrink ? w_sp_dec : r_sp;
            w_we            = w_grow;
            w_pop_data_nxt  = bus.POP_flag ? w_top : r_pop_data;
            w_pop_valid_nxt = bus.POP_flag;
         end
      end
`ifdef FLOW_FAULT_CLEAR_EN
      else if (r_state == S_FAULT && fault_clear) begin
         w_state_nxt = S_RUN;
         w_code_nxt  = 2'd0;
      end
`endif
   end
   // state and architectural registers; reset wins over step
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_RUN;
         r_pc        <= RESET_PC;
         r_sp        <= '0;
         r_pop_data  <= '0;
         r_pop_valid <= 1'b0;
         r_code      <= 2'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         r_sp        <= w_sp_nxt;
         r_pop_data  <= w_pop_data_nxt;
         r_pop_valid <= w_pop_valid_nxt;
         r_code      <= w_code_nxt;
      end
   end
   // stack storage is never cleared, only written by CALL/PUSH
   always_ff @(posedge clk) begin
      if (!rst && w_we) r_mem[w_wr_idx] <= w_wdata;
   end
   assign bus.PC_pos     = r_pc;
   assign bus.pop_data   = r_pop_data;
   assign bus.pop_valid  = r_pop_valid;
   assign bus.stack_ptr  = r_sp;
   assign bus.fault      = r_state == S_FAULT;
   assign bus.fault_code = r_code;
endmodule

// File: tb/tb_program_flow_unit.sv
// tb_program_flow_unit: directed vector bench for program_flow_unit
module tb_program_flow_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
`ifdef FLOW_FAULT_CLEAR_EN
   logic fault_clear = 1'b0;
`endif
   int n_cmp = 0;
   int n_bad = 0;
   always #5 clk = ~clk;
   program_flow_unit_if #(.SP_W(5)) bus ();
   program_flow_unit dut (
      .clk(clk),
      .rst(rst),
`ifdef FLOW_FAULT_CLEAR_EN
      .fault_clear(fault_clear),
`endif
      .bus(bus)
   );
   typedef struct {
      logic        r;
      logic        s;
      logic [4:0]  f;
      logic [15:0] tg;
      logic [31:0] pd;
      logic [15:0] e_pc;
      logic [4:0]  e_sp;
      logic [31:0] e_pd;
      logic        e_pv;
      logic        e_f;
      logic [1:0]  e_c;
   } vec_t;
   vec_t v [26];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic drive(input logic r, input logic s, input logic [4:0] f,
                        input logic [15:0] tg, input logic [31:0] pd);
      @(negedge clk);
      rst = r;
      bus.step = s;
      {bus.JMP_flag, bus.CALL_flag, bus.RET_flag, bus.PUSH_flag, bus.POP_flag} = f;
      bus.target = tg;
      bus.push_data = pd;
      @(posedge clk);
      #1;
   endtask
   task automatic chk_all(input string tag, input logic [15:0] pc, input logic [4:0] sp,
                          input logic [31:0] pdv, input logic pv, input logic f, input logic [1:0] c);
      chk({tag, " pc"}, 32'(bus.PC_pos), 32'(pc));
      chk({tag, " sp"}, 32'(bus.stack_ptr), 32'(sp));
      chk({tag, " pop_data"}, bus.pop_data, pdv);
      chk({tag, " pop_valid"}, 32'(bus.pop_valid), 32'(pv));
      chk({tag, " fault"}, 32'(bus.fault), 32'(f));
      chk({tag, " code"}, 32'(bus.fault_code), 32'(c));
   endtask
   localparam logic [4:0] NONE = 5'b00000, JMP = 5'b10000, CALL = 5'b01000,
                          RET = 5'b00100, PUSH = 5'b00010, POP = 5'b00001;
   initial begin
      v[0]  = '{1, 0, NONE, 16'h0, 32'h0, 16'h0000, 5'd0, 32'h0, 0, 0, 2'd0};
      v[1]  = '{0, 1, NONE, 16'h0, 32'h0, 16'h0001, 5'd0, 32'h0, 0, 0, 2'd0};
      v[2]  = '{0, 1, NONE, 16'h0, 32'h0, 16'h0002, 5'd0, 32'h0, 0, 0, 2'd0};
      v[3]  = '{0, 1, NONE, 16'h0, 32'h0, 16'h0003, 5'd0, 32'h0, 0, 0, 2'd0};
      v[4]  = '{0, 0, JMP,  16'h9, 32'h0, 16'h0003, 5'd0, 32'h0, 0, 0, 2'd0};
      v[5]  = '{0, 1, JMP,  16'h5, 32'h0, 16'h0005, 5'd0, 32'h0, 0, 0, 2'd0};
      v[6]  = '{0, 1, CALL, 16'h40, 32'h0, 16'h0040, 5'd1, 32'h0, 0, 0, 2'd0};
      v[7]  = '{0, 1, RET,  16'h0, 32'h0, 16'h0006, 5'd0, 32'h0, 0, 0, 2'd0};
      v[8]  = '{0, 1, PUSH, 16'h0, 32'hDEADBEEF, 16'h0007, 5'd1, 32'h0, 0, 0, 2'd0};
      v[9]  = '{0, 1, POP,  16'h0, 32'h0, 16'h0008, 5'd0, 32'hDEADBEEF, 1, 0, 2'd0};
      v[10] = '{0, 0, NONE, 16'h0, 32'h0, 16'h0008, 5'd0, 32'hDEADBEEF, 0, 0, 2'd0};
      v[11] = '{0, 1, JMP,  16'h8, 32'h0, 16'h0008, 5'd0, 32'hDEADBEEF, 0, 0, 2'd0};
      v[12] = '{0, 1, JMP,  16'h8, 32'h0, 16'h0008, 5'd0, 32'hDEADBEEF, 0, 0, 2'd0};
      v[13] = '{0, 1, JMP,  16'hFFFF, 32'h0, 16'hFFFF, 5'd0, 32'hDEADBEEF, 0, 0, 2'd0};
      v[14] = '{0, 1, NONE, 16'h0, 32'h0, 16'h0000, 5'd0, 32'hDEADBEEF, 0, 0, 2'd0};
      v[15] = '{0, 1, CALL, 16'hFFFF, 32'h0, 16'hFFFF, 5'd1, 32'hDEADBEEF, 0, 0, 2'd0};
      v[16] = '{0, 1, CALL, 16'h10, 32'h0, 16'h0010, 5'd2, 32'hDEADBEEF, 0, 0, 2'd0};
      v[17] = '{0, 1, RET,  16'h0, 32'h0, 16'h0000, 5'd1, 32'hDEADBEEF, 0, 0, 2'd0};
      v[18] = '{0, 1, RET,  16'h0, 32'h0, 16'h0001, 5'd0, 32'hDEADBEEF, 0, 0, 2'd0};
      v[19] = '{0, 1, POP,  16'h0, 32'h0, 16'h0001, 5'd0, 32'hDEADBEEF, 0, 1, 2'd2};
      v[20] = '{0, 1, JMP,  16'h7, 32'h0, 16'h0001, 5'd0, 32'hDEADBEEF, 0, 1, 2'd2};
      v[21] = '{1, 1, JMP,  16'h7, 32'h0, 16'h0000, 5'd0, 32'h0, 0, 0, 2'd0};
      v[22] = '{0, 1, JMP | CALL, 16'h40, 32'h0, 16'h0000, 5'd0, 32'h0, 0, 1, 2'd3};
      v[23] = '{1, 0, NONE, 16'h0, 32'h0, 16'h0000, 5'd0, 32'h0, 0, 0, 2'd0};
      v[24] = '{0, 1, RET,  16'h0, 32'h0, 16'h0000, 5'd0, 32'h0, 0, 1, 2'd2};
      v[25] = '{1, 0, NONE, 16'h0, 32'h0, 16'h0000, 5'd0, 32'h0, 0, 0, 2'd0};
      for (int i = 0; i < 26; i++) begin
         drive(v[i].r, v[i].s, v[i].f, v[i].tg, v[i].pd);
         chk_all($sformatf("v%0d", i), v[i].e_pc, v[i].e_sp, v[i].e_pd, v[i].e_pv, v[i].e_f, v[i].e_c);
      end
      for (int i = 0; i < 16; i++) begin
         drive(0, 1, PUSH, 16'h0, 32'hA000_0000 + 32'(i));
         chk($sformatf("push%0d sp", i), 32'(bus.stack_ptr), 32'(i + 1));
         chk($sformatf("push%0d pc", i), 32'(bus.PC_pos), 32'(i + 1));
      end
      drive(0, 1, POP, 16'h0, 32'h0);
      chk_all("pop15", 16'd17, 5'd15, 32'hA000_000F, 1, 0, 2'd0);
      drive(0, 1, POP, 16'h0, 32'h0);
      chk_all("pop14", 16'd18, 5'd14, 32'hA000_000E, 1, 0, 2'd0);
      drive(0, 1, PUSH, 16'h0, 32'hB000_0000);
      drive(0, 1, PUSH, 16'h0, 32'hB000_0001);
      chk_all("refill", 16'd20, 5'd16, 32'hA000_000E, 0, 0, 2'd0);
      drive(0, 1, PUSH, 16'h0, 32'hC000_0000);
      chk_all("overflow", 16'd20, 5'd16, 32'hA000_000E, 0, 1, 2'd1);
      drive(0, 1, POP, 16'h0, 32'h0);
      chk_all("frozen", 16'd20, 5'd16, 32'hA000_000E, 0, 1, 2'd1);
`ifdef FLOW_FAULT_CLEAR_EN
      @(negedge clk);
      bus.step = 1'b0;
      fault_clear = 1'b1;
      @(posedge clk);
      #1;
      fault_clear = 1'b0;
      chk_all("clear", 16'd20, 5'd16, 32'hA000_000E, 0, 0, 2'd0);
      drive(0, 1, POP, 16'h0, 32'h0);
      chk_all("resume", 16'd21, 5'd15, 32'hB000_0001, 1, 0, 2'd0);
`endif
      drive(1, 1, POP, 16'h0, 32'h0);
      chk_all("final_rst", 16'h0000, 5'd0, 32'h0, 0, 0, 2'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
